// File: rtl/fp_pkg.sv
// Shared constants, flag bit positions and FSM state encoding for the
// single-precision floating-point units.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [2:0] {IDLE, CLASSIFY, DIVIDE, ROUND, DONE} state_t;
endpackage

// File: rtl/fpdiv_es_execute.sv
// Divider sign/exponent stage: result sign and biased exponent difference
// as a signed value two bits wider than the exponent field.
module fpdiv_es_execute #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int BIAS  = fp_pkg::BIAS
) (
  input  logic                    sa,
  input  logic                    sb,
  input  logic [EXP_W-1:0]        ea,
  input  logic [EXP_W-1:0]        eb,
  output logic                    sign,
  output logic signed [EXP_W+1:0] exp_diff
);
  always_comb begin
    sign     = sa ^ sb;
    exp_diff = $signed({2'b00, ea}) - $signed({2'b00, eb})
             + $signed((EXP_W+2)'(BIAS));
  end
endmodule

// File: rtl/fpdiv_iterative.sv
// Single-precision divider: classify, radix-2 restoring mantissa divide
// (one quotient bit per cycle), round-to-nearest-even, valid/ready handshake.
module fpdiv_iterative #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int BIAS   = fp_pkg::BIAS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   a,
  input  logic [EXP_W+MANT_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   q,
  output logic [3:0]              flags
);
  import fp_pkg::*;

  localparam int W  = EXP_W + MANT_W + 1;
  localparam int M  = MANT_W + 1;
  localparam int QW = M + 2;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0]          LAST = CW'(QW - 1);
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ONE  = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] ZERO = '0;

  state_t state, next_state;

  logic [W-1:0]            a_r, b_r;
  logic [M:0]              rem, rem_sub, rem_sel;
  logic [M-1:0]            dvs;
  logic [QW-1:0]           quo, quo_n;
  logic [CW-1:0]           cnt;
  logic signed [EXP_W+1:0] exp_r, exp_diff, exp_n, exp_f;
  logic                    sign_r, sign, rem_ge;

  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic special;
  logic [W-1:0] spec_q, inf_val, zero_val, qnan_val, round_q;
  logic [3:0]   spec_flags, round_flags;

  logic [M-1:0]      mant;
  logic [M:0]        mant_r;
  logic [MANT_W-1:0] mant_f;
  logic              guard, sticky, round_up, ovf, unf;

  fpdiv_es_execute #(.EXP_W(EXP_W), .BIAS(BIAS)) u_es (
    .sa       (a_r[W-1]),
    .sb       (b_r[W-1]),
    .ea       (ea),
    .eb       (eb),
    .sign     (sign),
    .exp_diff (exp_diff)
  );

  // Denormals have a zero exponent and so classify as (signed) zero.
  always_comb begin
    ea = a_r[W-2:MANT_W];
    eb = b_r[W-2:MANT_W];
    fa = a_r[MANT_W-1:0];
    fb = b_r[MANT_W-1:0];
    a_zero = (ea == '0);
    a_inf  = (ea == '1) && (fa == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_zero = (eb == '0);
    b_inf  = (eb == '1) && (fb == '0);
    b_nan  = (eb == '1) && (fb != '0);

    inf_val  = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    zero_val = {sign, {(W-1){1'b0}}};
    qnan_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    special    = 1'b1;
    spec_q     = zero_val;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_q = qnan_val;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_q = inf_val;
      spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (a_inf) begin
      spec_q = inf_val;
    end else if (b_inf || a_zero) begin
      spec_q = zero_val;
    end else begin
      special = 1'b0;
    end
  end

  always_comb begin
    rem_ge  = (rem >= {1'b0, dvs});
    rem_sub = rem - {1'b0, dvs};
    rem_sel = rem_ge ? rem_sub : rem;
  end

  // Quotient lies in (0.5, 2): normalise first, then round, then renormalise on carry.
  always_comb begin
    quo_n    = quo[QW-1] ? quo : (quo << 1);
    exp_n    = quo[QW-1] ? exp_r : (exp_r - ONE);
    mant     = quo_n[QW-1:2];
    guard    = quo_n[1];
    sticky   = quo_n[0] | (rem != '0);
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + (M+1)'(round_up);
    if (mant_r[M]) begin
      mant_f = mant_r[MANT_W:1];
      exp_f  = exp_n + ONE;
    end else begin
      mant_f = mant_r[MANT_W-1:0];
      exp_f  = exp_n;
    end
    ovf = (exp_f >= EMAX);
    unf = (exp_f <= ZERO);
    round_flags = '0;
    if (ovf) begin
      round_q = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      round_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (unf) begin
      round_q = {sign_r, {(W-1){1'b0}}};
      round_flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      round_q = {sign_r, exp_f[EXP_W-1:0], mant_f};
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (in_valid && in_ready) next_state = CLASSIFY;
      CLASSIFY: next_state = special ? DONE : DIVIDE;
      DIVIDE:   if (cnt == LAST) next_state = ROUND;
      ROUND:    next_state = DONE;
      DONE:     if (out_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      rem       <= '0;
      dvs       <= '0;
      quo       <= '0;
      cnt       <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      q         <= '0;
      flags     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_r <= a;
          b_r <= b;
        end
        CLASSIFY: begin
          if (special) begin
            q     <= spec_q;
            flags <= spec_flags;
          end else begin
            rem    <= {2'b01, fa};
            dvs    <= {1'b1, fb};
            quo    <= '0;
            cnt    <= '0;
            exp_r  <= exp_diff;
            sign_r <= sign;
          end
        end
        DIVIDE: begin
          rem <= rem_sel << 1;
          quo <= {quo[QW-2:0], rem_ge};
          cnt <= cnt + 1'b1;
        end
        ROUND: begin
          q     <= round_q;
          flags <= round_flags;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpdiv_iterative.sv
// Scoreboard bench for fpdiv_iterative: directed vectors push expected
// results; an independent monitor checks each result, its latency and hold.
module tb_fpdiv_iterative;
  import fp_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  f;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, q;
  logic [3:0]  flags;

  exp_t sb[$];
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bp_req = 0;
  int   last_acc = 0;

  fpdiv_iterative dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flags     (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tbv,
                       input logic [31:0] eq, input logic [3:0] ef,
                       input int lat, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_wait: in_ready 0 after %0d cycles, expected 1", n);
    end else begin
      a        = ta;
      b        = tbv;
      in_valid = 1'b1;
      last_acc = cycle + 1;
      if (track) sb.push_back('{q: eq, f: ef, lat: lat, acc: cycle + 1});
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Monitor: compares results on first sight, then checks hold under backpressure.
  initial begin
    exp_t cur;
    bit   prev_ov, hs_pend;
    int   hold;
    out_ready = 1'b1;
    prev_ov   = 1'b0;
    hs_pend   = 1'b0;
    hold      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov   = 1'b0;
        hs_pend   = 1'b0;
        hold      = 0;
        out_ready = 1'b1;
      end else begin
        if (hs_pend) begin
          chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
          chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
          hs_pend = 1'b0;
        end
        if (out_valid) begin
          if (!prev_ov) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_result: got q=%h flags=%h expected no output", q, flags);
              cur = '{q: q, f: flags, lat: 0, acc: 0};
            end else begin
              cur = sb.pop_front();
              chk("q", q, cur.q);
              chk("flags", {28'd0, flags}, {28'd0, cur.f});
              chk("latency", 32'(cycle - cur.acc), 32'(cur.lat));
              hold   = bp_req;
              bp_req = 0;
            end
          end else begin
            chk("q_hold", q, cur.q);
            chk("flags_hold", {28'd0, flags}, {28'd0, cur.f});
          end
          chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
          end else begin
            out_ready = 1'b1;
            hs_pend   = 1'b1;
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    n_bad++;
    $display("FAIL watchdog: run exceeded 20000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);

    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 1'b1);
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, 1'b1);
    issue(32'h3F800000, 32'h00000000, POS_INF,      4'b0100, 1,  1'b1);
    issue(32'h00000000, 32'h00000000, QNAN,         4'b1000, 1,  1'b1);
    issue(32'h7F7FFFFF, 32'h3F000000, POS_INF,      4'b0010, 28, 1'b1);
    issue(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28, 1'b1);
    issue(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1,  1'b1);
    issue(32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 1,  1'b1);
    issue(32'h7F800001, 32'h3F800000, QNAN,         4'b1000, 1,  1'b1);
    issue(32'h7F800000, 32'h7F800000, QNAN,         4'b1000, 1,  1'b1);
    issue(32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000, 1,  1'b1);
    issue(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1,  1'b1);
    issue(32'hC0A00000, 32'h40000000, 32'hC0200000, 4'b0000, 28, 1'b1);

    bp_req = 10;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 1'b1);

    // Abort a divide at iteration 10; nothing may come out for it.
    issue(32'h40C00000, 32'h40000000, 32'h0, 4'b0, 0, 1'b0);
    while (cycle < last_acc + 11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_q", q, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_output", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready_back", {31'd0, in_ready}, 32'd1);

    issue(32'h41000000, 32'hC0000000, 32'hC0800000, 4'b0000, 28, 1'b1);

    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpdiv_iterative.md
Name: fpdiv_iterative

Overview:
- Single-precision IEEE-754 floating-point divider, q = a / b.
- Mantissa path is an iterative radix-2 restoring divider, one quotient bit per clock.
- Exponent and sign path computes Ea - Eb + BIAS and Sa ^ Sb.
- Sits beside the multiplier datapath and shares its operand/result handshake so the issue logic can drive either unit.

Parameters:
- EXP_W, 8, exponent field width
- MANT_W, 23, stored mantissa width; the datapath uses MANT_W+1 bits with the hidden 1
- BIAS, 127, exponent bias

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider can accept operands; high only in IDLE
- a  in  32  dividend
- b  in  32  divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- q  out  32  quotient
- flags  out  4  {invalid, div_by_zero, overflow, underflow}

Behaviour:
- Reset values: in_ready=0, out_valid=0, q=0, flags=0, state=IDLE. One cycle after rst deasserts, in_ready=1.
- Reset mid-operation discards all work in progress. No output appears for the discarded operation.
- Accept: in_valid && in_ready at a rising edge latches a and b, then moves to CLASSIFY. in_ready drops the same edge.
- Input handling: denormal inputs are flushed to signed zero. Sign is always Sa ^ Sb, except NaN results.
- CLASSIFY (1 cycle), special cases, which skip DIVIDE and go to DONE:
  - Any NaN operand, 0/0, or inf/inf → q=0x7FC00000, invalid=1
  - finite non-zero / 0 → signed inf, div_by_zero=1
  - inf / finite → signed inf
  - finite / inf → signed zero
  - 0 / non-zero finite → signed zero
  - Otherwise: load remainder R=Ma, divisor D=Mb, quotient register Q=0, iteration counter=0. E = Ea - Eb + BIAS as a 10-bit signed value. Go to DIVIDE.
- DIVIDE: 26 cycles, counter 0..25. Each cycle:
  - If R >= D: R ← 2(R-D) and shift 1 into Q; otherwise R ← 2R and shift 0 into Q.
  - Exit when counter == 25.
- ROUND (1 cycle):
  - If Q[25]=0 (Ma < Mb): shift Q left 1 and decrement E.
  - Mantissa = Q[25:2]; guard = Q[1]; sticky = Q[0] | (R != 0).
  - Round to nearest even. If the mantissa carries out, shift right and increment E.
  - E >= 255 → signed inf, overflow=1.
  - E <= 0 → signed zero, underflow=1.
- DONE: out_valid=1. q and flags stay stable while out_valid && !out_ready.
  - On out_ready, out_valid=0, go to IDLE, in_ready=1 next cycle.
  - No overlap: the next accept happens at least one cycle after the result handshake.
- Latency from accept edge to out_valid high:
  - Normal operands: 28 cycles (CLASSIFY 1 + DIVIDE 26 + ROUND 1).
  - Special cases: 1 cycle.
- in_valid while busy is ignored. The producer holds the operands until in_ready.

Decomposition:
- Package fp_pkg holds:
  - EXP_W, MANT_W, BIAS
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000
  - Flag bit indices
  - State enum {IDLE, CLASSIFY, DIVIDE, ROUND, DONE}
- Sub-module fpdiv_es_execute: combinational sign XOR plus the 10-bit signed exponent difference Ea - Eb + BIAS. It is the divide counterpart of the multiplier's exponent/sign stage.
- The FSM, mantissa divider and rounding stay in the top module.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0) → q=0x40400000, flags=0, out_valid exactly 28 cycles after accept.
- a=0x3F800000 (1.0), b=0x40400000 (3.0) → q=0x3EAAAAAB (Ma<Mb normalization, round-up), flags=0.
- a=0x3F800000, b=0x00000000 → q=0x7F800000, div_by_zero=1, 1-cycle latency. a=0, b=0 → q=0x7FC00000, invalid=1.
- a=0x7F7FFFFF, b=0x3F000000 (0.5) → q=0x7F800000, overflow=1. a=0x00800000, b=0x40000000 → q=0x00000000, underflow=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid → q and flags stable, in_ready=0 throughout. out_ready=1 → in_ready=1 on the next cycle.
- Assert rst at DIVIDE iteration 10 → out_valid=0 and in_ready=0 immediately. After release, 8.0/(-2.0) (0x41000000/0xC0000000) → q=0xC0800000.
